// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one 16-bit async SRAM between the VGA scan-out read requester and
//   the tile-streaming write requester. Each grant runs a fixed-length SRAM
//   cycle (READ or WRITE for ACCESS_CYCLES clocks), then a single DONE
//   turnaround cycle that carries the ack. Reads have priority.
//
//   Optional feature macro: TYPHOON_ARB_STARVE_GUARD_EN
//     defined   : a streak counter forces a write after STARVE_LIMIT
//                 consecutive read grants that each saw wr_req pending.
//     undefined : strict read priority; writes go only when rd_req is low.
//
// Ports
//   BOARD_CLK, Reset          clock, synchronous active-high reset
//   rd_req/rd_addr            read request (level) and word address
//   rd_ack/rd_data            ack pulse; data valid with ack, held until next
//   wr_req/wr_addr/wr_data    write request (level), address, data
//   wr_ack                    ack pulse once the write has completed
//   busy                      high whenever the FSM is not IDLE
//   SRAM_*                    SRAM address, data bus and active-low strobes
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        BOARD_CLK,
  input  logic        Reset,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  input  logic        wr_req,
  input  logic [19:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_ack_q, rd_ack_d;
  logic          wr_ack_q, wr_ack_d;
  logic          busy_q, busy_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          force_wr;

`ifdef TYPHOON_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  logic [SW-1:0] streak_q, streak_d;
  assign force_wr = wr_req && (streak_q == SW'(STARVE_LIMIT));
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
    streak_d  = streak_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd_req && !force_wr) begin
          state_d = READ;
          cnt_d   = '0;
          addr_d  = rd_addr;
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
          // only reads that overtake a waiting write count toward the streak
          streak_d = wr_req ? streak_q + SW'(1) : '0;
`endif
        end else if (wr_req) begin
          state_d = WRITE;
          cnt_d   = '0;
          addr_d  = wr_addr;
          wdata_d = wr_data;
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
          streak_d = '0;
`endif
        end else begin
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
          streak_d = '0;
`endif
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          state_d   = DONE;
          rd_data_d = SRAM_DQ;
          rd_ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d  = DONE;
          wr_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;  // DONE: turnaround, no arbitration
    endcase

    // Strobes are registered, so decode them from the state being entered.
    // WE_N rises in the last write cycle to give the SRAM data hold time.
    ce_n_d = !((state_d == READ) || (state_d == WRITE));
    oe_n_d = (state_d != READ);
    we_n_d = !((state_d == WRITE) && (cnt_d != LAST));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge BOARD_CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
      streak_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
`ifdef TYPHOON_ARB_STARVE_GUARD_EN
      streak_q  <= streak_d;
`endif
    end
  end

  // Bus is driven for the whole WRITE state, including the WE_N-high hold cycle.
  assign SRAM_DQ   = (state_q == WRITE) ? wdata_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ce_n_q;
  assign SRAM_LB_N = ce_n_q;
  assign rd_ack    = rd_ack_q;
  assign wr_ack    = wr_ack_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;

endmodule
